// File: rtl/aes256_key_expand_ctrl.sv
// aes256_key_expand_ctrl: sequences AES-256 key expansion around an external word generator and serves 128-bit round keys
//
// Loads an 8-word cipher key, then steps i=8..59. Each cycle it presents
// w[i-1] and w[i-8] to the combinational generator (current_word_gen_256)
// and stores the returned w[i] in a 60-word schedule. Round keys 0..14 are
// read out as {w[4k], w[4k+1], w[4k+2], w[4k+3]}.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start                    request expansion of key (ignored while busy)
//   key                      cipher key, key[255:224] is w[0]
//   busy                     expansion in progress
//   done                     one-cycle pulse after w[59] is written
//   key_valid                schedule complete and readable
//   gen_i, gen_prev_word,
//   gen_prev_period_word     index, w[i-1] and w[i-8] to the generator
//   gen_current_word         generator result w[i]
//   rk_idx, rk_out           round-key select 0..14 and round-key data
//
// Configuration macro KEYEXP_RK_REG_EN: when defined, rk_out is registered
// (one cycle after rk_idx); otherwise it is combinational from rk_idx.
module aes256_key_expand_ctrl #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 60,
  parameter int KEY_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [KEY_WORDS*WORD_W-1:0]   key,
  output logic                          busy,
  output logic                          done,
  output logic                          key_valid,
  output logic [5:0]                    gen_i,
  output logic [WORD_W-1:0]             gen_prev_word,
  output logic [WORD_W-1:0]             gen_prev_period_word,
  input  logic [WORD_W-1:0]             gen_current_word,
  input  logic [3:0]                    rk_idx,
  output logic [4*WORD_W-1:0]           rk_out
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  state_t state, state_nx;
  logic [5:0] i;
  logic [WORD_W-1:0] w [NUM_WORDS];
  logic load, exp_last;
  logic [5:0] rk_base;
  logic [4*WORD_W-1:0] rk_sel;
  assign load     = (state != EXPAND) && start;
  assign exp_last = (state == EXPAND) && (i == 6'(NUM_WORDS - 1));
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? EXPAND : IDLE;
      EXPAND:  state_nx = exp_last ? READY : EXPAND;
      READY:   state_nx = start ? EXPAND : READY;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy                 = state == EXPAND;
    key_valid            = state == READY;
    gen_i                = busy ? i : 6'd0;
    gen_prev_word        = busy ? w[i - 6'd1] : '0;
    gen_prev_period_word = busy ? w[i - 6'(KEY_WORDS)] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      i    <= 6'd0;
      done <= 1'b0;
    end else begin
      done <= exp_last;
      i    <= load ? 6'(KEY_WORDS) : (busy ? i + 6'd1 : i);
    end
  end
  // Schedule storage is deliberately not reset; key_valid gates every read.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < KEY_WORDS; k++)
        w[k] <= key[(KEY_WORDS-1-k)*WORD_W +: WORD_W];
    end else if (busy) begin
      w[i] <= gen_current_word;
    end
  end
  // rk_idx 15 would address words 60..63, which do not exist.
  always_comb begin
    rk_base = {rk_idx, 2'b00};
    rk_sel  = (key_valid && rk_idx != 4'd15) ?
              {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]} : '0;
  end
`ifdef KEYEXP_RK_REG_EN
  always_ff @(posedge clk) begin
    if (rst) rk_out <= '0;
    else     rk_out <= rk_sel;
  end
`else
  assign rk_out = rk_sel;
`endif
endmodule

// File: tb/tb_aes256_key_expand_ctrl.sv
// tb_aes256_key_expand_ctrl: directed self-checking bench with a behavioural AES-256 word generator
module tb_aes256_key_expand_ctrl;
  localparam logic [255:0] KEY = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [127:0] RK1  = 128'h1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [127:0] RK2  = 128'h9ba35411_8e6925af_a51a8b5f_2067fcde;
  localparam logic [127:0] RK14 = 128'hfe4890d1_e6188d0b_046df344_706c631e;
  localparam logic [127:0] Z_RK2 = 128'h62636363_62636363_62636363_62636363;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic clk = 0, rst, start, busy, done, key_valid;
  logic [255:0] key;
  logic [5:0] gen_i;
  logic [31:0] gen_prev_word, gen_prev_period_word, gen_current_word;
  logic [3:0] rk_idx;
  logic [127:0] rk_out;
  logic [31:0] mw [60];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] subw(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = SBOX[(255 - int'(x[b*8 +: 8]))*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] gen_fn(input logic [5:0] idx, input logic [31:0] p, input logic [31:0] pp);
    logic [31:0] t;
    logic [7:0] rc;
    t = p;
    rc = 8'h01 << (idx[5:3] - 3'd1);
    if (idx[2:0] == 3'd0) t = subw({p[23:0], p[31:24]}) ^ {rc, 24'h0};
    else if (idx[2:0] == 3'd4) t = subw(p);
    return pp ^ t;
  endfunction

  assign gen_current_word = gen_fn(gen_i, gen_prev_word, gen_prev_period_word);

  aes256_key_expand_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .busy(busy), .done(done),
    .key_valid(key_valid), .gen_i(gen_i), .gen_prev_word(gen_prev_word),
    .gen_prev_period_word(gen_prev_period_word), .gen_current_word(gen_current_word),
    .rk_idx(rk_idx), .rk_out(rk_out));

  task automatic model_expand(input logic [255:0] k);
    for (int j = 0; j < 8; j++) mw[j] = k[255 - 32*j -: 32];
    for (int j = 8; j < 60; j++) mw[j] = gen_fn(6'(j), mw[j-1], mw[j-8]);
  endtask

  task automatic pulse_start(input logic [255:0] k);
    key = k;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic set_rk(input logic [3:0] r);
    rk_idx = r;
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    for (int n = 0; n < 80 && !key_valid; n++) @(negedge clk);
    checks++;
    if (key_valid !== 1'b1) begin failures++; $display("FAIL %s_timeout key_valid=%b exp=1", name, key_valid); end
  endtask

  task automatic wait_gen_i(input logic [5:0] target, input string name);
    for (int n = 0; n < 80 && gen_i !== target; n++) @(negedge clk);
    checks++;
    if (gen_i !== target) begin failures++; $display("FAIL %s_gen_i got=%0d exp=%0d", name, gen_i, target); end
  endtask

  task automatic test_reset;
    rst = 1; start = 0; key = '0; rk_idx = 4'd2;
    repeat (2) @(negedge clk);
    rst = 0;
    checks++;
    if ({busy, done, key_valid} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, key_valid}); end
    checks++;
    if (gen_i !== 6'd0 || gen_prev_word !== 32'h0 || gen_prev_period_word !== 32'h0) begin
      failures++; $display("FAIL reset_gen got=%0d/%h/%h exp=0/0/0", gen_i, gen_prev_word, gen_prev_period_word);
    end
    checks++;
    if (rk_out !== 128'h0) begin failures++; $display("FAIL reset_rk got=%h exp=0", rk_out); end
  endtask

  task automatic test_expand;
    int nb, nd;
    nb = 0; nd = 0;
    pulse_start(KEY);
    checks++;
    if (gen_i !== 6'd8 || gen_prev_word !== 32'h0914dff4 || gen_prev_period_word !== 32'h603deb10) begin
      failures++; $display("FAIL first_gen got=%0d/%h/%h exp=8/0914dff4/603deb10", gen_i, gen_prev_word, gen_prev_period_word);
    end
    for (int n = 0; n < 60; n++) begin
      if (busy) nb++;
      if (done) nd++;
      @(negedge clk);
    end
    checks++;
    if (nb != 52) begin failures++; $display("FAIL busy_cycles got=%0d exp=52", nb); end
    checks++;
    if (nd != 1) begin failures++; $display("FAIL done_pulses got=%0d exp=1", nd); end
    checks++;
    if (key_valid !== 1'b1) begin failures++; $display("FAIL key_valid got=%b exp=1", key_valid); end
    set_rk(4'd2);
    checks++;
    if (rk_out !== RK2) begin failures++; $display("FAIL rk2 got=%h exp=%h", rk_out, RK2); end
  endtask

  task automatic test_round_keys;
    set_rk(4'd14);
    checks++;
    if (rk_out !== RK14) begin failures++; $display("FAIL rk14 got=%h exp=%h", rk_out, RK14); end
    set_rk(4'd1);
    checks++;
    if (rk_out !== RK1) begin failures++; $display("FAIL rk1 got=%h exp=%h", rk_out, RK1); end
    set_rk(4'd15);
    checks++;
    if (rk_out !== 128'h0) begin failures++; $display("FAIL rk15 got=%h exp=0", rk_out); end
  endtask

  task automatic test_restart_ignored;
    pulse_start(KEY);
    wait_gen_i(6'd20, "ign");
    pulse_start('0);
    key = KEY;
    checks++;
    if (busy !== 1'b1 || gen_i !== 6'd21) begin failures++; $display("FAIL ign_busy got=%b/%0d exp=1/21", busy, gen_i); end
    wait_ready("ign");
    set_rk(4'd1);
    checks++;
    if (rk_out !== RK1) begin failures++; $display("FAIL ign_rk1 got=%h exp=%h", rk_out, RK1); end
    set_rk(4'd14);
    checks++;
    if (rk_out !== RK14) begin failures++; $display("FAIL ign_rk14 got=%h exp=%h", rk_out, RK14); end
  endtask

  task automatic test_reset_mid;
    pulse_start(KEY);
    wait_gen_i(6'd30, "rstmid");
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if (busy !== 1'b0 || key_valid !== 1'b0 || gen_i !== 6'd0) begin
      failures++; $display("FAIL rstmid_state got=%b/%b/%0d exp=0/0/0", busy, key_valid, gen_i);
    end
    repeat (3) @(negedge clk);
    set_rk(4'd2);
    checks++;
    if (key_valid !== 1'b0 || rk_out !== 128'h0) begin failures++; $display("FAIL rstmid_gate got=%b/%h exp=0/0", key_valid, rk_out); end
    pulse_start(KEY);
    wait_ready("rerun");
    set_rk(4'd2);
    checks++;
    if (rk_out !== RK2) begin failures++; $display("FAIL rerun_rk2 got=%h exp=%h", rk_out, RK2); end
    set_rk(4'd14);
    checks++;
    if (rk_out !== RK14) begin failures++; $display("FAIL rerun_rk14 got=%h exp=%h", rk_out, RK14); end
  endtask

  task automatic test_ready_restart;
    logic [127:0] z14;
    model_expand('0);
    z14 = {mw[56], mw[57], mw[58], mw[59]};
    checks++;
    if (key_valid !== 1'b1) begin failures++; $display("FAIL ready_pre got=%b exp=1", key_valid); end
    pulse_start('0);
    checks++;
    if (key_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ready_drop got=%b/%b exp=0/1", key_valid, busy); end
    @(negedge clk);
    checks++;
    if (rk_out !== 128'h0) begin failures++; $display("FAIL ready_gate got=%h exp=0", rk_out); end
    wait_ready("zero");
    set_rk(4'd2);
    checks++;
    if (rk_out !== Z_RK2) begin failures++; $display("FAIL zero_rk2 got=%h exp=%h", rk_out, Z_RK2); end
    rk_idx = 4'd14;
    #1;
    checks++;
`ifdef KEYEXP_RK_REG_EN
    if (rk_out !== Z_RK2) begin failures++; $display("FAIL rk_lag got=%h exp=%h", rk_out, Z_RK2); end
`else
    if (rk_out !== z14) begin failures++; $display("FAIL rk_comb got=%h exp=%h", rk_out, z14); end
`endif
    @(negedge clk);
    checks++;
    if (rk_out !== z14) begin failures++; $display("FAIL zero_rk14 got=%h exp=%h", rk_out, z14); end
  endtask

  initial begin
    test_reset;
    test_expand;
    test_round_keys;
    test_restart_ignored;
    test_reset_mid;
    test_ready_restart;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
